// File: rtl/test_mailbox_pkg.sv
// Shared types and constants for the test mailbox responder.
// Verdict encoding, register offsets and the default pass code.
package test_mailbox_pkg;

  typedef enum logic [1:0] {
    RUNNING = 2'b00,
    PASS    = 2'b01,
    FAIL    = 2'b10,
    TIMEOUT = 2'b11
  } verdict_t;

  localparam logic [1:0] OFF_TRACE   = 2'd0;
  localparam logic [1:0] OFF_VERDICT = 2'd1;
  localparam logic [1:0] OFF_DEPTH   = 2'd2;
  localparam logic [1:0] OFF_ZERO    = 2'd3;

  localparam logic [7:0] DEFAULT_PASS_CODE = 8'h42;

  localparam int CNT_W = 5;

endpackage

// File: rtl/mailbox_fifo.sv
// Trace byte FIFO for the test mailbox.
// Head output reads as zero while empty; push while full is accepted only with a pop.
module mailbox_fifo
  import test_mailbox_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem[rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/test_mailbox.sv
// Memory-mapped verdict/trace mailbox for self-checking test ROMs.
// TEST_MAILBOX_WATCHDOG_EN builds the watchdog and the TIMEOUT verdict.
module test_mailbox
  import test_mailbox_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR      = 16'h0200,
  parameter int          DEPTH          = 8,
  parameter logic [7:0]  PASS_CODE      = DEFAULT_PASS_CODE,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        ph2,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        we,
  output logic [7:0]  rdata,
  output logic        hit,
  output logic        drain_valid,
  output logic [7:0]  drain_data,
  input  logic        drain_ready,
  output logic        done,
  output logic        pass
);

  verdict_t         state;
  verdict_t         state_n;
  logic [1:0]       off;
  logic             push;
  logic             pop;
  logic             vwr;
  logic             wd_hit;
  logic             overflow;
  logic [7:0]       last_trace;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  assign hit  = (addr[15:2] == BASE_ADDR[15:2]);
  assign off  = addr[1:0];
  assign push = hit && we && (off == OFF_TRACE);
  assign vwr  = hit && we && (off == OFF_VERDICT);
  assign pop  = drain_valid && drain_ready;

  mailbox_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (ph2),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (wdata),
    .dout (drain_data),
    .count(count),
    .full (full),
    .empty(empty)
  );

  assign drain_valid = !empty;

  always_ff @(posedge ph2) begin
    if (reset) begin
      overflow   <= 1'b0;
      last_trace <= 8'h00;
    end else if (push) begin
      last_trace <= wdata;
      if (full && !pop) overflow <= 1'b1;
    end
  end

`ifdef TEST_MAILBOX_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd;

  always_ff @(posedge ph2) begin
    if (reset) begin
      wd <= '0;
    end else if (state == RUNNING && wd != WD_MAX) begin
      wd <= wd + 1'b1;
    end
  end

  // This edge is the one on which the count reaches the limit.
  assign wd_hit = (wd == WD_LAST);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge ph2) begin
    if (reset) state <= RUNNING;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RUNNING: begin
        if (vwr)         state_n = (wdata == PASS_CODE) ? PASS : FAIL;
        else if (wd_hit) state_n = TIMEOUT;
      end
      default: state_n = state;
    endcase
  end

  always_comb begin
    done = (state != RUNNING);
    pass = (state == PASS);
  end

  always_comb begin
    rdata = 8'h00;
    if (hit) begin
      unique case (off)
        OFF_TRACE:   rdata = last_trace;
        OFF_VERDICT: rdata = {state, overflow, count};
        OFF_DEPTH:   rdata = 8'(DEPTH);
        OFF_ZERO:    rdata = 8'h00;
        default:     rdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_test_mailbox.sv
// Bench for test_mailbox: queue-based reference model plus directed pins.
// Build with or without TEST_MAILBOX_WATCHDOG_EN.
module tb_test_mailbox;

  localparam logic [15:0] BASE = 16'h0200;
  localparam int          DEP  = 8;
  localparam int          TO   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = 16'h0;
  logic [7:0]  wdata = 8'h0;
  logic        we = 1'b0;
  logic        drain_ready = 1'b0;
  logic [7:0]  rdata;
  logic        hit;
  logic        drain_valid;
  logic [7:0]  drain_data;
  logic        done;
  logic        pass;

  int n_vec = 0;
  int n_bad = 0;

  test_mailbox #(
    .BASE_ADDR     (BASE),
    .DEPTH         (DEP),
    .PASS_CODE     (8'h42),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .ph2        (clk),
    .reset      (reset),
    .addr       (addr),
    .wdata      (wdata),
    .we         (we),
    .rdata      (rdata),
    .hit        (hit),
    .drain_valid(drain_valid),
    .drain_data (drain_data),
    .drain_ready(drain_ready),
    .done       (done),
    .pass       (pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: verdict as a 0..3 code, trace as a queue.
  logic [7:0] q[$];
  logic [1:0] m_st = 2'd0;
  logic       m_over = 1'b0;
  logic [7:0] m_last = 8'h0;
  int         m_cyc = 0;
  bit         armed = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_st = 2'd0;
      m_over = 1'b0;
      m_last = 8'h0;
      m_cyc = 0;
      armed = 1'b1;
    end else begin
      bit mh;
      bit pp;
      int sz;
      mh = (addr[15:2] == BASE[15:2]);
      sz = q.size();
      pp = (sz > 0) && drain_ready;
      if (pp) void'(q.pop_front());
      if (mh && we && addr[1:0] == 2'd0) begin
        m_last = wdata;
        if (sz < DEP || pp) q.push_back(wdata);
        else m_over = 1'b1;
      end
      if (m_st == 2'd0) begin
        m_cyc++;
        if (mh && we && addr[1:0] == 2'd1)
          m_st = (wdata == 8'h42) ? 2'd1 : 2'd2;
`ifdef TEST_MAILBOX_WATCHDOG_EN
        else if (m_cyc >= TO)
          m_st = 2'd3;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      logic       eh;
      logic [7:0] er;
      eh = (addr[15:2] == BASE[15:2]);
      er = 8'h00;
      if (eh) begin
        case (addr[1:0])
          2'd0: er = m_last;
          2'd1: er = {m_st, m_over, 5'(q.size())};
          2'd2: er = 8'(DEP);
          default: er = 8'h00;
        endcase
      end
      chk("hit", {7'b0, hit}, {7'b0, eh});
      chk("rdata", rdata, er);
      chk("done", {7'b0, done}, {7'b0, m_st != 2'd0});
      chk("pass", {7'b0, pass}, {7'b0, m_st == 2'd1});
      chk("drain_valid", {7'b0, drain_valid}, {7'b0, q.size() > 0});
      chk("drain_data", drain_data, (q.size() > 0) ? q[0] : 8'h00);
    end
  end

  task automatic setin(input logic [15:0] a, input logic [7:0] d,
                       input logic w, input logic r);
    addr = a;
    wdata = d;
    we = w;
    drain_ready = r;
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d,
                       input logic w, input logic r);
    setin(a, d, w, r);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(16'h0, 8'h0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_l[$];
    int o;
    int sel;

    do_reset();
    drive(16'h0, 8'h0, 1'b0, 1'b0);
    setin(16'h0201, 8'h0, 1'b0, 1'b0);
    chk("reset_status", rdata, 8'h00);
    chk("reset_done", {7'b0, done}, 8'h00);
    chk("reset_valid", {7'b0, drain_valid}, 8'h00);
    chk("reset_ddata", drain_data, 8'h00);

    do_reset();
    drive(16'h0201, 8'h42, 1'b1, 1'b0);
    setin(16'h0201, 8'h0, 1'b0, 1'b0);
    chk("pass_done", {7'b0, done}, 8'h01);
    chk("pass_pass", {7'b0, pass}, 8'h01);
    chk("pass_status", rdata, 8'h40);

    do_reset();
    drive(16'h0201, 8'h13, 1'b1, 1'b0);
    drive(16'h0201, 8'h42, 1'b1, 1'b0);
    setin(16'h0201, 8'h0, 1'b0, 1'b0);
    chk("fail_pass", {7'b0, pass}, 8'h00);
    chk("fail_status", rdata, 8'h80);

    do_reset();
    for (int i = 1; i <= 10; i++) drive(16'h0200, 8'(i), 1'b1, 1'b0);
    setin(16'h0201, 8'h0, 1'b0, 1'b0);
    chk("ovf_status", rdata, 8'h28);
    setin(16'h0200, 8'h0, 1'b0, 1'b0);
    chk("ovf_last", rdata, 8'h0A);
    for (int i = 1; i <= 8; i++) begin
      setin(16'h0, 8'h0, 1'b0, 1'b1);
      chk("ovf_valid", {7'b0, drain_valid}, 8'h01);
      chk("ovf_drain", drain_data, 8'(i));
      @(posedge clk);
      #1;
    end
    chk("ovf_empty", {7'b0, drain_valid}, 8'h00);

    do_reset();
    for (int i = 1; i <= 8; i++) drive(16'h0200, 8'(i), 1'b1, 1'b0);
    drive(16'h0200, 8'hAA, 1'b1, 1'b1);
    setin(16'h0201, 8'h0, 1'b0, 1'b0);
    chk("fullpp_status", rdata, 8'h08);
    exp_l = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};
    foreach (exp_l[k]) begin
      setin(16'h0, 8'h0, 1'b0, 1'b1);
      chk("fullpp_drain", drain_data, exp_l[k]);
      @(posedge clk);
      #1;
    end
    chk("fullpp_empty", {7'b0, drain_valid}, 8'h00);

    do_reset();
`ifdef TEST_MAILBOX_WATCHDOG_EN
    for (int i = 0; i < TO - 1; i++) drive(16'h0, 8'h0, 1'b0, 1'b0);
    chk("wd_early", {7'b0, done}, 8'h00);
    drive(16'h0, 8'h0, 1'b0, 1'b0);
    setin(16'h0201, 8'h0, 1'b0, 1'b0);
    chk("wd_done", {7'b0, done}, 8'h01);
    chk("wd_pass", {7'b0, pass}, 8'h00);
    chk("wd_status", rdata, 8'hC0);
`else
    for (int i = 0; i < 100; i++) drive(16'h0, 8'h0, 1'b0, 1'b0);
    chk("nowd_done", {7'b0, done}, 8'h00);
`endif

    do_reset();
    for (int i = 0; i < 3; i++) drive(16'h0200, 8'(8'h50 + i), 1'b1, 1'b0);
    drive(16'h0201, 8'h42, 1'b1, 1'b0);
    chk("rst_pre_done", {7'b0, done}, 8'h01);
    reset = 1'b1;
    drive(16'h0200, 8'h77, 1'b1, 1'b1);
    reset = 1'b0;
    setin(16'h0201, 8'h0, 1'b0, 1'b0);
    chk("rst_done", {7'b0, done}, 8'h00);
    chk("rst_valid", {7'b0, drain_valid}, 8'h00);
    chk("rst_status", rdata, 8'h00);
    setin(16'h0200, 8'h0, 1'b0, 1'b0);
    chk("rst_last", rdata, 8'h00);

    for (int n = 0; n < 3000; n++) begin
      logic [15:0] a;
      logic [7:0]  d;
      sel = $urandom_range(0, 9);
      o = $urandom_range(0, 15);
      if (sel < 8)
        a = BASE + 16'((o < 10) ? 0 : (o < 11) ? 1 : (o < 13) ? 2 : 3);
      else
        a = 16'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 8'h42 : 8'($urandom);
      reset = ($urandom_range(0, 59) == 0);
      drive(a, d, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0));
    end
    reset = 1'b0;
    drive(16'h0, 8'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/test_mailbox.md
# test_mailbox

Memory-mapped responder that sits on the 6502 data bus beside `mem` in `top`. It is the target end of the CPU's memory-write traffic for self-checking test ROMs. The CPU writes trace bytes and a final verdict code into a four-byte window. The block buffers the trace bytes in a FIFO, latches a sticky PASS/FAIL/TIMEOUT verdict, and drains the trace to the bench over a valid/ready port. Benches therefore check a verdict instead of peeking RAM.

## Interface
Parameters:
- `BASE_ADDR`, 16'h0200: base of the 4-byte register window (offsets +0..+3).
- `DEPTH`, 8: number of trace FIFO entries; power of two, 2..16.
- `PASS_CODE`, 8'h42: verdict value meaning pass.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in `ph2` cycles.

Ports:
- `ph2`, input, 1: the only clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `addr`, input, 16: CPU address bus.
- `wdata`, input, 8: CPU write data.
- `we`, input, 1: CPU write strobe; 0 means read.
- `rdata`, output, 8: read data. Combinational from registered state; valid whenever `addr` is in the window.
- `hit`, output, 1: `addr` is in the window; the top level uses it to steer `rdata` over `mem`.
- `drain_valid`, output, 1: the FIFO head is available.
- `drain_data`, output, 8: the FIFO head byte.
- `drain_ready`, input, 1: the bench accepts the head.
- `done`, output, 1: the verdict state is not RUNNING.
- `pass`, output, 1: the verdict state is PASS.

## Operation
Register map. Only `addr[1:0]` are decoded once `hit` is set.
- +0 TRACE
  - Write pushes `wdata` into the FIFO and into `last_trace`.
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and `overflow` is set (sticky). `last_trace` still updates.
  - Read returns `last_trace`.
- +1 VERDICT
  - Write while RUNNING: `wdata == PASS_CODE` moves to PASS; any other value moves to FAIL.
  - Write while not RUNNING is ignored.
  - Read returns `{state[1:0], overflow, count[4:0]}`.
- +2: write ignored; read returns `DEPTH`.
- +3: write ignored; read returns 8'h00.

Verdict state machine. Encoding: RUNNING=00, PASS=01, FAIL=10, TIMEOUT=11.
- RUNNING → PASS or FAIL on a VERDICT write, as above.
- RUNNING → TIMEOUT when the watchdog reaches `TIMEOUT_CYCLES`.
- PASS, FAIL and TIMEOUT are absorbing until `reset`.

Watchdog:
- Counts every `ph2` cycle while RUNNING and saturates.
- If a VERDICT write lands in the same cycle the count reaches the limit, the VERDICT write wins.

FIFO:
- Pop occurs when `drain_valid && drain_ready`.
- Push and pop in the same cycle both take effect and `count` is unchanged. This includes the full case: the push is accepted.
- The FIFO keeps accepting pushes and pops after a verdict.
- Pointers wrap modulo `DEPTH`.
- `count` ranges 0..DEPTH.

## Timing
- Writes take effect at the `ph2` edge on which `hit && we` holds.
- Read-back reflects a write from the following cycle onward.
- Verdict latency is 1 cycle: `done` and `pass` rise on the edge after the VERDICT write.
- `drain_valid` rises on the edge after the first push into an empty FIFO; there is no bypass path.
- `drain_valid` stays high and `drain_data` stays stable until accepted.
- Reset values:
  - `rdata` reflects zeroed state.
  - `drain_valid` = 0, `drain_data` = 8'h00.
  - `done` = 0, `pass` = 0.
  - state = RUNNING, count = 0, overflow = 0, watchdog = 0, `last_trace` = 8'h00.
- `reset` asserted mid-run, including with a full FIFO or a latched verdict, clears everything on that edge. Pushes and pops in that cycle are discarded.

## Configuration
- `TEST_MAILBOX_WATCHDOG_EN`
  - Defined: the watchdog counter and the TIMEOUT transition are built.
  - Undefined: no counter exists, TIMEOUT is unreachable and `TIMEOUT_CYCLES` is unused. The state only leaves RUNNING through a VERDICT write.

## Structure
- Package `test_mailbox_pkg` holds:
  - the `verdict_t` enum (2-bit encoding above);
  - the offset constants `OFF_TRACE`, `OFF_VERDICT`, `OFF_DEPTH`, `OFF_ZERO`;
  - the default `PASS_CODE`.
- Sub-module `mailbox_fifo`: parameterised by `DEPTH`, with push/pop ports, `count` and `full`/`empty` outputs.
- The top-level block contains the decode, the state machine, the watchdog and the read mux.

## Test plan
- Reset, then write 8'h42 to 16'h0201 → `done`=1 and `pass`=1 one cycle later; read 16'h0201 = 8'h40.
- Write 8'h13 to VERDICT → state FAIL, `pass`=0. A later write of 8'h42 is ignored and the state stays FAIL.
- Push 10 bytes 8'h01..8'h0A with `drain_ready`=0 and DEPTH=8 → count=8 and overflow=1; status reads 8'h28; the drain yields 8'h01..8'h08 in order.
- With the FIFO full, push 8'hAA while popping → count stays 8, overflow stays 0, and 8'hAA drains last.
- With `TEST_MAILBOX_WATCHDOG_EN` and TIMEOUT_CYCLES=16, issue no VERDICT → state TIMEOUT at cycle 16 after reset, `done`=1 and `pass`=0. Without the macro, `done` stays 0 for 100 cycles.
- Assert `reset` for 1 cycle with PASS latched and 3 bytes queued → next cycle `done`=0, `drain_valid`=0, status reads 8'h00.
